icache_fetch_responder: RTL

Slave end of `core2icache_if`. It accepts block-aligned fetch requests from the frontend fetcher and returns the requested cacheline plus the following cacheline two cycles after grant. It is a direct-mapped, two-bank (even/odd line) instruction cache, so `line0` and `line1` can be read in the same cycle. Misses are serviced one line at a time through a simple refill port to the memory side.

---
 rtl/icache_fetch_responder_pkg.sv | 18 +
 rtl/icache_fetch_responder_if.sv | 15 +
 rtl/icache_bank.sv | 32 +++
 rtl/icache_fetch_responder.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/icache_fetch_responder_pkg.sv
// Shared types for the instruction-cache fetch responder: line/block widths, FSM states, S1 request record.
package icache_fetch_responder_pkg;
  localparam int CACHELINE_SIZE = 8;
  localparam int LINE_W         = CACHELINE_SIZE * 8;
  localparam int BLK_W          = 16;
  localparam int ICACHE_SETS    = 64;

  typedef logic [BLK_W-1:0]  blk_t;
  typedef logic [LINE_W-1:0] line_t;

  typedef enum logic [1:0] {IDLE, REQ, WAIT} icache_state_t;

  typedef struct packed {
    logic vld;
    logic get2;
    blk_t addr;
  } fetch_req_t;
endpackage

// File: rtl/icache_fetch_responder_if.sv
// Frontend fetcher to icache request/response bundle; the cache is the slave end.
interface core2icache_if;
  import icache_fetch_responder_pkg::*;

  logic  req;
  blk_t  addr;
  logic  get2;
  logic  gnt;
  logic  rsp;
  line_t line0;
  line_t line1;

  modport m (output req, addr, get2, input gnt, rsp, line0, line1);
  modport s (input req, addr, get2, output gnt, rsp, line0, line1);
endinterface

// File: rtl/icache_bank.sv
// One direct-mapped bank: tag+data arrays with a registered read port and one write port.
module icache_bank
  import icache_fetch_responder_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int IDX_W = 5,
  parameter int TAG_W = 10
) (
  input  logic             clk,
  input  logic             rd_en,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [TAG_W-1:0] rd_tag,
  output line_t            rd_data,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0] wr_tag,
  input  line_t            wr_data
);
  logic [TAG_W-1:0] tag_mem  [DEPTH];
  line_t            data_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_mem[wr_idx]  <= wr_tag;
      data_mem[wr_idx] <= wr_data;
    end
    if (rd_en) begin
      rd_tag  <= tag_mem[rd_idx];
      rd_data <= data_mem[rd_idx];
    end
  end
endmodule

// File: rtl/icache_fetch_responder.sv
// Two-bank direct-mapped icache: hits answer 2 cycles after grant, one per cycle.
// Misses drop gnt, refill one line at a time, and the requester re-issues.
module icache_fetch_responder
  import icache_fetch_responder_pkg::*;
#(
  parameter int SETS = ICACHE_SETS
) (
  input  logic          clk,
  input  logic          rst,
  core2icache_if.s      if_core_fetch,
  input  logic          i_fence_i,
  output logic          o_refill_req,
  output blk_t          o_refill_addr,
  input  logic          i_refill_gnt,
  input  logic          i_refill_vld,
  input  line_t         i_refill_data
);
  localparam int SET_W = $clog2(SETS);
  localparam int IDX_W = SET_W - 1;
  localparam int TAG_W = BLK_W - SET_W;
  localparam int NSET  = SETS / 2;

  function automatic logic [IDX_W-1:0] set_of(blk_t b);
    return b[SET_W-1:1];
  endfunction

  function automatic logic [TAG_W-1:0] tag_of(blk_t b);
    return b[BLK_W-1:SET_W];
  endfunction

  icache_state_t state_q, state_d;
  blk_t          refill_addr_q, refill_addr_d, second_q, second_d;
  logic          pend2_q, pend2_d, fenced_q, fenced_d;
  logic          fill_we, fill_set_vld;

  logic [1:0][NSET-1:0] valid_q;
  fetch_req_t           s1_q;
  logic                 rsp_q;
  line_t                line0_q, line1_q;

  // S0: addr and addr+1 always land in opposite banks, so both read in one cycle
  logic take;
  blk_t a1_s0, even_s0, odd_s0;
  assign take    = if_core_fetch.req && if_core_fetch.gnt;
  assign a1_s0   = if_core_fetch.addr + blk_t'(1);
  assign even_s0 = if_core_fetch.addr[0] ? a1_s0 : if_core_fetch.addr;
  assign odd_s0  = if_core_fetch.addr[0] ? if_core_fetch.addr : a1_s0;

  logic [TAG_W-1:0] tag_even, tag_odd;
  line_t            data_even, data_odd;

  icache_bank #(.DEPTH(NSET), .IDX_W(IDX_W), .TAG_W(TAG_W)) u_bank_even (
    .clk(clk), .rd_en(take), .rd_idx(set_of(even_s0)), .rd_tag(tag_even), .rd_data(data_even),
    .wr_en(fill_we && !refill_addr_q[0]), .wr_idx(set_of(refill_addr_q)),
    .wr_tag(tag_of(refill_addr_q)), .wr_data(i_refill_data)
  );

  icache_bank #(.DEPTH(NSET), .IDX_W(IDX_W), .TAG_W(TAG_W)) u_bank_odd (
    .clk(clk), .rd_en(take), .rd_idx(set_of(odd_s0)), .rd_tag(tag_odd), .rd_data(data_odd),
    .wr_en(fill_we && refill_addr_q[0]), .wr_idx(set_of(refill_addr_q)),
    .wr_tag(tag_of(refill_addr_q)), .wr_data(i_refill_data)
  );

  // S1: tag compare against the registered request
  blk_t a1_s1, even_s1, odd_s1;
  logic hit_even, hit_odd, hit0, hit1, s1_hit, s1_miss, miss0, miss1;
  assign a1_s1    = s1_q.addr + blk_t'(1);
  assign even_s1  = s1_q.addr[0] ? a1_s1 : s1_q.addr;
  assign odd_s1   = s1_q.addr[0] ? s1_q.addr : a1_s1;
  assign hit_even = valid_q[0][set_of(even_s1)] && (tag_even == tag_of(even_s1));
  assign hit_odd  = valid_q[1][set_of(odd_s1)]  && (tag_odd  == tag_of(odd_s1));
  assign hit0     = s1_q.addr[0] ? hit_odd  : hit_even;
  assign hit1     = s1_q.addr[0] ? hit_even : hit_odd;
  assign s1_hit   = hit0 && (!s1_q.get2 || hit1);
  assign s1_miss  = s1_q.vld && !s1_hit;
  assign miss0    = !hit0;
  assign miss1    = s1_q.get2 && !hit1;

  assign if_core_fetch.gnt   = (state_q == IDLE) && !s1_miss && !i_fence_i;
  assign if_core_fetch.rsp   = rsp_q;
  assign if_core_fetch.line0 = line0_q;
  assign if_core_fetch.line1 = line1_q;
  assign o_refill_addr       = refill_addr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q    <= '0;
      rsp_q   <= 1'b0;
      line0_q <= '0;
      line1_q <= '0;
    end else begin
      s1_q  <= '{vld: take, get2: if_core_fetch.get2, addr: if_core_fetch.addr};
      rsp_q <= s1_q.vld && s1_hit && !i_fence_i;
      if (s1_q.vld && s1_hit) begin
        line0_q <= s1_q.addr[0] ? data_odd  : data_even;
        line1_q <= s1_q.addr[0] ? data_even : data_odd;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
    end else if (i_fence_i) begin
      valid_q <= '0;
    end else if (fill_set_vld) begin
      valid_q[refill_addr_q[0]][set_of(refill_addr_q)] <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      refill_addr_q <= '0;
      second_q      <= '0;
      pend2_q       <= 1'b0;
      fenced_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      refill_addr_q <= refill_addr_d;
      second_q      <= second_d;
      pend2_q       <= pend2_d;
      fenced_q      <= fenced_d;
    end
  end

  // A fence seen anywhere during a refill poisons the fill and drops the pending second line
  always_comb begin
    state_d       = state_q;
    refill_addr_d = refill_addr_q;
    second_d      = second_q;
    pend2_d       = pend2_q;
    fenced_d      = fenced_q || i_fence_i;
    fill_we       = 1'b0;
    fill_set_vld  = 1'b0;
    o_refill_req  = (state_q == REQ);
    case (state_q)
      IDLE: begin
        fenced_d = 1'b0;
        if (s1_miss && !i_fence_i) begin
          state_d       = REQ;
          refill_addr_d = miss0 ? s1_q.addr : a1_s1;
          second_d      = a1_s1;
          pend2_d       = miss0 && miss1;
        end
      end
      REQ: begin
        if (i_refill_gnt) state_d = WAIT;
      end
      WAIT: begin
        if (i_refill_vld) begin
          fill_we      = 1'b1;
          fill_set_vld = !(fenced_q || i_fence_i);
          pend2_d      = 1'b0;
          if (pend2_q && fill_set_vld) begin
            state_d       = REQ;
            refill_addr_d = second_q;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end
endmodule
